hazard_ctrl: RTL and testbench

- Hazard and forwarding controller for the 5-stage pipeline.
- Tracks in-flight destination tags for the EX, MEM and WB stages in its own shadow pipeline.
- Drives the per-operand bypass enables consumed by the register file in decode.
- Generates load-use stalls, multi-cycle multiply holds and bubble insertion for fetch/decode/EX.

---
 rtl/hazard_ctrl_pkg.sv | 30 +++
 rtl/hazard_match.sv | 30 +++
 rtl/hazard_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/forwarding controller.
// Contents: register index width, bypass-bit positions, the in-flight slot
// record tracked per stage, and the per-cycle pipeline action encoding.
package hazard_ctrl_pkg;

    localparam int unsigned ADDR_SIZE = 5;

    // Bit positions inside every {ra,rb} bypass bus.
    localparam logic BP_RA = 1'b1;
    localparam logic BP_RB = 1'b0;

    // One in-flight instruction as seen by the hazard logic.
    typedef struct packed {
        logic                 v;
        logic                 wr;
        logic [ADDR_SIZE-1:0] rd;
        logic                 ld;
    } slot_t;

    localparam slot_t SLOT_NONE = '0;

    // What the slot pipeline does on the coming edge.
    typedef enum logic [1:0] {
        ACT_NORMAL = 2'd0,
        ACT_HOLD   = 2'd1,
        ACT_FLUSH  = 2'd2,
        ACT_STALL  = 2'd3
    } action_e;

endpackage

// File: rtl/hazard_match.sv
// Combinational {ra,rb} match of one pipeline slot against the decode sources.
// Ports: slot (tracked slot), src_a/src_b (decode source indices),
//        use_a/use_b (operand actually read), hit (2-bit {ra,rb} match).
module hazard_match
    import hazard_ctrl_pkg::*;
(
    input  slot_t                slot,
    input  logic [ADDR_SIZE-1:0] src_a,
    input  logic [ADDR_SIZE-1:0] src_b,
    input  logic                 use_a,
    input  logic                 use_b,
    output logic [1:0]           hit
);

    logic live;
    logic unused_ld;

    // The load flag is consumed by the controller, not by the comparator.
    assign unused_ld = slot.ld;

    // x0 is hard-wired zero and never produces a forward.
    assign live = slot.v & slot.wr & (slot.rd != '0);

    always_comb begin
        hit        = 2'b00;
        hit[BP_RA] = live & use_a & (slot.rd == src_a);
        hit[BP_RB] = live & use_b & (slot.rd == src_b);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline.
// Keeps a shadow EX/MEM/WB pipeline of destination tags, drives the decode
// bypass enables, and produces load-use stalls, multiply holds and bubbles.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   D_*                      decode-stage instruction fields
//   flush                    taken branch/jump resolved in EX
//   EX_D_bp/MEM_D_bp/WB_D_bp {ra,rb} bypass enables per producing stage
//   D_stall                  freeze PC and F/D
//   EX_bubble                load NOP into D/EX
//   EX_hold                  hold D/EX (multiply in progress)
//   MEM_bubble               load NOP into EX/MEM
//   mul_busy                 multiply counter non-zero
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned CNT_W   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 D_valid,
    input  logic [ADDR_SIZE-1:0] D_ra,
    input  logic [ADDR_SIZE-1:0] D_rb,
    input  logic                 D_use_ra,
    input  logic                 D_use_rb,
    input  logic [ADDR_SIZE-1:0] D_rd,
    input  logic                 D_we,
    input  logic                 D_link_we,
    input  logic                 D_ld,
    input  logic                 D_mul,
    input  logic                 flush,
    output logic [1:0]           EX_D_bp,
    output logic [1:0]           MEM_D_bp,
    output logic [1:0]           WB_D_bp,
    output logic                 D_stall,
    output logic                 EX_bubble,
    output logic                 EX_hold,
    output logic                 MEM_bubble,
    output logic                 mul_busy
);

    slot_t            ex_slot;
    slot_t            mem_slot;
    slot_t            wb_slot;
    slot_t            d_slot;
    logic [CNT_W-1:0] mul_cnt;
    logic             started;
    logic [1:0]       ex_hit;
    logic [1:0]       mem_hit;
    logic [1:0]       wb_hit;
    logic             cnt_busy;
    logic             load_use;
    action_e          act;

    // Per-stage source comparators.
    hazard_match u_match_ex (
        .slot  (ex_slot),
        .src_a (D_ra),
        .src_b (D_rb),
        .use_a (D_use_ra),
        .use_b (D_use_rb),
        .hit   (ex_hit)
    );

    hazard_match u_match_mem (
        .slot  (mem_slot),
        .src_a (D_ra),
        .src_b (D_rb),
        .use_a (D_use_ra),
        .use_b (D_use_rb),
        .hit   (mem_hit)
    );

    hazard_match u_match_wb (
        .slot  (wb_slot),
        .src_a (D_ra),
        .src_b (D_rb),
        .use_a (D_use_ra),
        .use_b (D_use_rb),
        .hit   (wb_hit)
    );

    assign cnt_busy = (mul_cnt != '0);
    assign d_slot   = '{v: D_valid, wr: D_we | D_link_we, rd: D_rd, ld: D_ld};

    // A load in EX has no data yet; the consumer waits one cycle for MEM.
    assign load_use = D_valid & ex_slot.v & ex_slot.ld & (ex_slot.rd != '0) &
                      ((D_use_ra & (ex_slot.rd == D_ra)) |
                       (D_use_rb & (ex_slot.rd == D_rb)));

    // Pipeline action for this cycle. Until the first edge after reset the
    // controller stays passive so every output reads 0.
    always_comb begin
        act = ACT_NORMAL;
        if (started) begin
            if (cnt_busy) begin
                act = ACT_HOLD;
            end else if (flush) begin
                act = ACT_FLUSH;
            end else if (load_use) begin
                act = ACT_STALL;
            end
        end
    end

    // Shadow slot pipeline and multiply counter, mirroring the datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_slot  <= SLOT_NONE;
            mem_slot <= SLOT_NONE;
            wb_slot  <= SLOT_NONE;
            mul_cnt  <= '0;
            started  <= 1'b0;
        end else begin
            started <= 1'b1;
            wb_slot <= mem_slot;
            unique case (act)
                ACT_HOLD: begin
                    mem_slot <= SLOT_NONE;
                    mul_cnt  <= mul_cnt - CNT_W'(1);
                end
                ACT_FLUSH, ACT_STALL: begin
                    mem_slot <= ex_slot;
                    ex_slot  <= SLOT_NONE;
                end
                ACT_NORMAL: begin
                    mem_slot <= ex_slot;
                    ex_slot  <= d_slot;
                    if (D_valid && D_mul && (MUL_LAT > 1)) begin
                        mul_cnt <= CNT_W'(MUL_LAT - 1);
                    end
                end
                default: begin
                    mem_slot <= ex_slot;
                end
            endcase
        end
    end

    // Stall/bubble controls decoded from the action.
    always_comb begin
        D_stall    = 1'b0;
        EX_bubble  = 1'b0;
        EX_hold    = 1'b0;
        MEM_bubble = 1'b0;
        unique case (act)
            ACT_HOLD: begin
                D_stall    = 1'b1;
                EX_hold    = 1'b1;
                MEM_bubble = 1'b1;
            end
            ACT_FLUSH: begin
                EX_bubble = 1'b1;
            end
            ACT_STALL: begin
                D_stall   = 1'b1;
                EX_bubble = 1'b1;
            end
            default: begin
                D_stall = 1'b0;
            end
        endcase
    end

    // Bypass buses; the EX path is withheld while its result is not ready.
    always_comb begin
        EX_D_bp  = 2'b00;
        MEM_D_bp = 2'b00;
        WB_D_bp  = 2'b00;
        mul_busy = 1'b0;
        if (started) begin
            EX_D_bp  = (ex_slot.ld || cnt_busy) ? 2'b00 : ex_hit;
            MEM_D_bp = mem_hit;
            WB_D_bp  = wb_hit;
            mul_busy = cnt_busy;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed instruction sequences, a
// cycle-level reference model compared every cycle, and literal checks.
module tb_hazard_ctrl;

    localparam int MUL_LAT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       D_valid = 1'b0;
    logic [4:0] D_ra = '0;
    logic [4:0] D_rb = '0;
    logic       D_use_ra = 1'b0;
    logic       D_use_rb = 1'b0;
    logic [4:0] D_rd = '0;
    logic       D_we = 1'b0;
    logic       D_link_we = 1'b0;
    logic       D_ld = 1'b0;
    logic       D_mul = 1'b0;
    logic       flush = 1'b0;
    logic [1:0] EX_D_bp;
    logic [1:0] MEM_D_bp;
    logic [1:0] WB_D_bp;
    logic       D_stall;
    logic       EX_bubble;
    logic       EX_hold;
    logic       MEM_bubble;
    logic       mul_busy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .D_valid    (D_valid),
        .D_ra       (D_ra),
        .D_rb       (D_rb),
        .D_use_ra   (D_use_ra),
        .D_use_rb   (D_use_rb),
        .D_rd       (D_rd),
        .D_we       (D_we),
        .D_link_we  (D_link_we),
        .D_ld       (D_ld),
        .D_mul      (D_mul),
        .flush      (flush),
        .EX_D_bp    (EX_D_bp),
        .MEM_D_bp   (MEM_D_bp),
        .WB_D_bp    (WB_D_bp),
        .D_stall    (D_stall),
        .EX_bubble  (EX_bubble),
        .EX_hold    (EX_hold),
        .MEM_bubble (MEM_bubble),
        .mul_busy   (mul_busy)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       live;
        logic       writes;
        logic [4:0] dst;
        logic       is_load;
    } rec_t;

    rec_t m_ex      = '0;
    rec_t m_mem     = '0;
    rec_t m_wb      = '0;
    int   mul_left  = 0;
    logic m_started = 1'b0;

    logic [1:0] e_ex, e_mem, e_wb;
    logic       e_stall, e_exbub, e_hold, e_mbub, e_busy, e_lu;

    function automatic logic produces(input rec_t r, input logic [4:0] src, input logic used);
        return r.live && r.writes && (r.dst != 5'd0) && used && (r.dst == src);
    endfunction

    always_comb begin
        e_ex = 2'b00; e_mem = 2'b00; e_wb = 2'b00;
        e_stall = 1'b0; e_exbub = 1'b0; e_hold = 1'b0; e_mbub = 1'b0;
        e_busy = 1'b0; e_lu = 1'b0;
        if (!rst && m_started) begin
            e_busy = (mul_left > 0);
            e_mem  = {produces(m_mem, D_ra, D_use_ra), produces(m_mem, D_rb, D_use_rb)};
            e_wb   = {produces(m_wb, D_ra, D_use_ra), produces(m_wb, D_rb, D_use_rb)};
            if (!m_ex.is_load && !e_busy)
                e_ex = {produces(m_ex, D_ra, D_use_ra), produces(m_ex, D_rb, D_use_rb)};
            e_lu = D_valid && m_ex.live && m_ex.is_load && (m_ex.dst != 5'd0) &&
                   ((D_use_ra && m_ex.dst == D_ra) || (D_use_rb && m_ex.dst == D_rb));
            if (e_busy) begin
                e_stall = 1'b1; e_hold = 1'b1; e_mbub = 1'b1;
            end else if (flush) begin
                e_exbub = 1'b1;
            end else if (e_lu) begin
                e_stall = 1'b1; e_exbub = 1'b1;
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ex <= '0; m_mem <= '0; m_wb <= '0;
            mul_left <= 0; m_started <= 1'b0;
        end else begin
            m_started <= 1'b1;
            m_wb <= m_mem;
            if (e_hold) begin
                m_mem    <= '0;
                mul_left <= mul_left - 1;
            end else begin
                m_mem <= m_ex;
                if (e_exbub) begin
                    m_ex <= '0;
                end else begin
                    m_ex     <= {D_valid, D_we | D_link_we, D_rd, D_ld};
                    mul_left <= (D_valid && D_mul) ? MUL_LAT - 1 : 0;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ex_bp"}, EX_D_bp, 2'b00);
        chk({tag, "_mem_bp"}, MEM_D_bp, 2'b00);
        chk({tag, "_wb_bp"}, WB_D_bp, 2'b00);
        chk({tag, "_stall"}, {1'b0, D_stall}, 2'b00);
        chk({tag, "_exbub"}, {1'b0, EX_bubble}, 2'b00);
        chk({tag, "_hold"}, {1'b0, EX_hold}, 2'b00);
        chk({tag, "_mbub"}, {1'b0, MEM_bubble}, 2'b00);
        chk({tag, "_busy"}, {1'b0, mul_busy}, 2'b00);
    endtask

    // Model comparison on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("m_ex_bp", EX_D_bp, e_ex);
            chk("m_mem_bp", MEM_D_bp, e_mem);
            chk("m_wb_bp", WB_D_bp, e_wb);
            chk("m_stall", {1'b0, D_stall}, {1'b0, e_stall});
            chk("m_exbub", {1'b0, EX_bubble}, {1'b0, e_exbub});
            chk("m_hold", {1'b0, EX_hold}, {1'b0, e_hold});
            chk("m_mbub", {1'b0, MEM_bubble}, {1'b0, e_mbub});
            chk("m_busy", {1'b0, mul_busy}, {1'b0, e_busy});
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_d(input logic v, input logic [4:0] rd, input logic we, input logic lnk,
                         input logic ld, input logic mul, input logic [4:0] ra, input logic [4:0] rb,
                         input logic ura, input logic urb, input logic fl);
        D_valid = v; D_rd = rd; D_we = we; D_link_we = lnk; D_ld = ld; D_mul = mul;
        D_ra = ra; D_rb = rb; D_use_ra = ura; D_use_rb = urb; flush = fl;
    endtask

    task automatic cyc(input logic v, input logic [4:0] rd, input logic we, input logic lnk,
                       input logic ld, input logic mul, input logic [4:0] ra, input logic [4:0] rb,
                       input logic ura, input logic urb, input logic fl);
        @(posedge clk);
        #1;
        set_d(v, rd, we, lnk, ld, mul, ra, rb, ura, urb, fl);
        @(negedge clk);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        chk_zero("in_reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        chk_zero("after_release");
        nops(2);

        // ADD x3 then readers of x3
        cyc(1, 3, 1, 0, 0, 0, 1, 2, 1, 1, 0);
        cyc(1, 4, 1, 0, 0, 0, 3, 3, 1, 1, 0);
        chk("add_ex_bp", EX_D_bp, 2'b11);
        chk("add_stall", {1'b0, D_stall}, 2'b00);
        cyc(1, 9, 1, 0, 0, 0, 3, 3, 1, 1, 0);
        chk("add_mem_bp", MEM_D_bp, 2'b11);
        chk("add_ex_bp2", EX_D_bp, 2'b00);
        nops(3);

        // LD x5 then ADD x6,x5,x1
        cyc(1, 5, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 6, 1, 0, 0, 0, 5, 1, 1, 1, 0);
        chk("lu_stall", {1'b0, D_stall}, 2'b01);
        chk("lu_exbub", {1'b0, EX_bubble}, 2'b01);
        chk("lu_ex_bp", EX_D_bp, 2'b00);
        cyc(1, 6, 1, 0, 0, 0, 5, 1, 1, 1, 0);
        chk("lu_mem_bp", MEM_D_bp, 2'b10);
        chk("lu_stall_end", {1'b0, D_stall}, 2'b00);
        nops(3);

        // MUL x7 then ADD x8,x0,x7; a stray flush mid-hold must not kill the MUL
        cyc(1, 7, 1, 0, 0, 1, 1, 2, 1, 1, 0);
        cyc(1, 8, 1, 0, 0, 0, 0, 7, 1, 1, 0);
        chk("mul_stall1", {1'b0, D_stall}, 2'b01);
        chk("mul_hold1", {1'b0, EX_hold}, 2'b01);
        chk("mul_mbub1", {1'b0, MEM_bubble}, 2'b01);
        chk("mul_busy1", {1'b0, mul_busy}, 2'b01);
        chk("mul_ex_bp1", EX_D_bp, 2'b00);
        cyc(1, 8, 1, 0, 0, 0, 0, 7, 1, 1, 1);
        chk("mul_stall2", {1'b0, D_stall}, 2'b01);
        chk("mul_hold2", {1'b0, EX_hold}, 2'b01);
        chk("mul_busy2", {1'b0, mul_busy}, 2'b01);
        chk("mul_flush_ign", {1'b0, EX_bubble}, 2'b00);
        cyc(1, 8, 1, 0, 0, 0, 0, 7, 1, 1, 0);
        chk("mul_ex_bp3", EX_D_bp, 2'b01);
        chk("mul_stall3", {1'b0, D_stall}, 2'b00);
        chk("mul_busy3", {1'b0, mul_busy}, 2'b00);
        nops(3);

        // x0 never forwards or stalls; JALX link write forwards
        cyc(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0);
        chk("x0_ld_stall", {1'b0, D_stall}, 2'b00);
        chk("x0_ex_bp", EX_D_bp, 2'b00);
        cyc(1, 2, 1, 0, 0, 0, 0, 0, 1, 1, 0);
        chk("x0_ex_bp2", EX_D_bp, 2'b00);
        chk("x0_mem_bp", MEM_D_bp, 2'b00);
        cyc(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 2, 1, 0, 0, 0, 1, 3, 1, 1, 0);
        chk("link_ex_bp", EX_D_bp, 2'b10);
        nops(3);

        // flush overrides a pending load-use
        cyc(1, 5, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 6, 1, 0, 0, 0, 5, 1, 1, 1, 1);
        chk("fl_exbub", {1'b0, EX_bubble}, 2'b01);
        chk("fl_stall", {1'b0, D_stall}, 2'b00);
        cyc(1, 9, 1, 0, 0, 0, 5, 6, 1, 1, 0);
        chk("fl_ex_bp", EX_D_bp, 2'b00);
        chk("fl_mem_bp", MEM_D_bp, 2'b10);
        chk("fl_stall2", {1'b0, D_stall}, 2'b00);
        nops(3);

        // load feeding a MUL, then back-to-back MULs
        cyc(1, 10, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 11, 1, 0, 0, 1, 10, 1, 1, 1, 0);
        chk("ldmul_stall", {1'b0, D_stall}, 2'b01);
        chk("ldmul_busy", {1'b0, mul_busy}, 2'b00);
        cyc(1, 11, 1, 0, 0, 1, 10, 1, 1, 1, 0);
        chk("ldmul_go", {1'b0, D_stall}, 2'b00);
        cyc(1, 12, 1, 0, 0, 1, 2, 3, 1, 1, 0);
        chk("b2b_stall1", {1'b0, D_stall}, 2'b01);
        cyc(1, 12, 1, 0, 0, 1, 2, 3, 1, 1, 0);
        chk("b2b_stall2", {1'b0, D_stall}, 2'b01);
        cyc(1, 12, 1, 0, 0, 1, 2, 3, 1, 1, 0);
        chk("b2b_go", {1'b0, D_stall}, 2'b00);
        nops(1);
        chk("b2b_busy", {1'b0, mul_busy}, 2'b01);
        nops(5);

        // reset while the multiply counter is 1
        cyc(1, 7, 1, 0, 0, 1, 1, 2, 1, 1, 0);
        cyc(1, 8, 1, 0, 0, 0, 0, 7, 1, 1, 0);
        cyc(1, 8, 1, 0, 0, 0, 0, 7, 1, 1, 0);
        chk("rst_pre_busy", {1'b0, mul_busy}, 2'b01);
        #2 rst = 1'b1;
        #1 chk_zero("rst_mid_mul");
        @(posedge clk);
        #1 rst = 1'b0;
        set_d(1, 13, 1, 0, 0, 0, 7, 7, 1, 1, 0);
        @(negedge clk);
        chk_zero("rst_rel");
        cyc(1, 14, 1, 0, 0, 0, 13, 1, 1, 1, 0);
        chk("rst_after_bp", EX_D_bp, 2'b10);
        chk("rst_after_stall", {1'b0, D_stall}, 2'b00);
        nops(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
